// File: rtl/mul64_shift_add_seq.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier controller.
// Drives an external combinational WIDTH-bit adder each cycle and registers
// its sum and carry-out into a (2*WIDTH+1)-bit right-shifting accumulator.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 request pulse, accepted only in IDLE or DONE
//   multiplicand          operand A, captured on accepted start
//   multiplier            operand B, captured on accepted start
//   busy                  high while iterating
//   done                  one-cycle pulse when product_lo/product_hi are valid
//   product_lo/hi         low/high halves of A*B, held until the next result
//   add_a/add_b/add_c_in  operands to the external adder
//   add_sum/add_c_out     results from the external adder
module mul64_shift_add_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_c_in,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_c_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prod_lo_d, prod_hi_d;
  logic             busy_d, done_d;

  // Adder operands: add the multiplicand only when the current multiplier bit is set.
  assign add_a    = acc_hi_q;
  assign add_b    = acc_lo_q[0] ? mcand_q : '0;
  assign add_c_in = 1'b0;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      cnt_q      <= '0;
      product_lo <= '0;
      product_hi <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      cnt_q      <= cnt_d;
      product_lo <= prod_lo_d;
      product_hi <= prod_hi_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    prod_lo_d = product_lo;
    prod_hi_d = product_hi;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = multiplicand;
          acc_lo_d = multiplier;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        // Carry-out becomes the new MSB so the 2*WIDTH+1 bit partial sum is never truncated.
        {acc_hi_d, acc_lo_d} = {add_c_out, add_sum, acc_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          prod_hi_d = add_c_out ? {1'b1, add_sum[WIDTH-1:1]} : {1'b0, add_sum[WIDTH-1:1]};
          prod_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_mul64_shift_add_seq.sv
// Self-checking bench for mul64_shift_add_seq; supplies a behavioural 64-bit adder
// and checks results against a plain 128-bit multiply reference.
module tb_mul64_shift_add_seq;

  localparam int unsigned W = 64;
  localparam int unsigned LAT = 64;
  localparam int unsigned BOUND = 300;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand, multiplier;
  logic         busy, done;
  logic [W-1:0] product_lo, product_hi;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_c_in, add_c_out;
  logic [W:0]   sum_full;

  int n_checks = 0;
  int n_fail   = 0;

  mul64_shift_add_seq #(.WIDTH(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done),
    .product_lo(product_lo), .product_hi(product_hi),
    .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in),
    .add_sum(add_sum), .add_c_out(add_c_out)
  );

  // Stand-in for the external Sixty_Four_Bit_Adder.
  assign sum_full  = {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_c_in);
  assign add_sum   = sum_full[W-1:0];
  assign add_c_out = sum_full[W];

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    ref_mul = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Present operands with start for one accepting edge; returns at the negedge after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  // Observe a running operation until done; reports edges since acceptance and run-time observations.
  task automatic wait_done(input int first_edge, output int edges, output int busy_bad,
                           output int addb_nz, output int carries, output int carry_bad);
    logic prev_cout;
    edges = first_edge; busy_bad = 0; addb_nz = 0; carries = 0; carry_bad = 0;
    prev_cout = 1'b0;
    while (edges < int'(BOUND)) begin
      if (prev_cout && add_a[W-1] !== 1'b1) carry_bad++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_bad++;
      if (add_b !== '0) addb_nz++;
      if (add_c_out === 1'b1) carries++;
      prev_cout = add_c_out;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
    end
    n_checks++;
    if (product_lo !== '0 || product_hi !== '0) begin
      n_fail++; $display("FAIL reset_prod: lo=%h hi=%h required 0", product_lo, product_hi);
    end
    n_checks++;
    if (add_a !== '0 || add_b !== '0 || add_c_in !== 1'b0) begin
      n_fail++; $display("FAIL reset_adder: a=%h b=%h cin=%b required 0", add_a, add_b, add_c_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int e, bb, nz, cy, cb;
    issue(64'd3, 64'd5);
    wait_done(0, e, bb, nz, cy, cb);
    n_checks++;
    if (e != int'(LAT)) begin
      n_fail++; $display("FAIL basic_latency: %0d edges required %0d", e, LAT);
    end
    n_checks++;
    if (bb != 0) begin
      n_fail++; $display("FAIL basic_busy: %0d cycles busy low during run required 0", bb);
    end
    n_checks++;
    if (product_lo !== 64'd15 || product_hi !== 64'd0) begin
      n_fail++; $display("FAIL basic_product: hi=%h lo=%h required 0 f", product_hi, product_lo);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_done: busy=%b required 0", busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_single_pulse: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_all_ones();
    int e, bb, nz, cy, cb;
    issue('1, '1);
    wait_done(0, e, bb, nz, cy, cb);
    n_checks++;
    if (product_hi !== 64'hFFFF_FFFF_FFFF_FFFE || product_lo !== 64'h1) begin
      n_fail++; $display("FAIL ones_product: hi=%h lo=%h required fffffffffffffffe 1", product_hi, product_lo);
    end
    n_checks++;
    if (cy == 0) begin
      n_fail++; $display("FAIL ones_carries_seen: %0d carry cycles required >0", cy);
    end
    n_checks++;
    if (cb != 0) begin
      n_fail++; $display("FAIL ones_carry_capture: %0d lost carries required 0", cb);
    end
  endtask

  task automatic test_zero();
    int e, bb, nz, cy, cb;
    issue(64'd0, 64'h1234);
    wait_done(0, e, bb, nz, cy, cb);
    n_checks++;
    if (nz != 0) begin
      n_fail++; $display("FAIL zero_a_addb: %0d cycles add_b nonzero required 0", nz);
    end
    n_checks++;
    if (product_lo !== '0 || product_hi !== '0 || e != int'(LAT)) begin
      n_fail++; $display("FAIL zero_a_product: hi=%h lo=%h edges=%0d required 0 0 %0d", product_hi, product_lo, e, LAT);
    end
    issue(64'h1234, 64'd0);
    wait_done(0, e, bb, nz, cy, cb);
    n_checks++;
    if (product_lo !== '0 || product_hi !== '0 || e != int'(LAT)) begin
      n_fail++; $display("FAIL zero_b_product: hi=%h lo=%h edges=%0d required 0 0 %0d", product_hi, product_lo, e, LAT);
    end
  endtask

  task automatic test_start_ignored();
    int e, bb, nz, cy, cb, pulses;
    logic [2*W-1:0] exp_p;
    exp_p = ref_mul(64'hDEAD_BEEF_0123_4567, 64'h0FED_CBA9_8765_4321);
    issue(64'hDEAD_BEEF_0123_4567, 64'h0FED_CBA9_8765_4321);
    repeat (20) @(negedge clk);
    multiplicand = 64'd7; multiplier = 64'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(21, e, bb, nz, cy, cb);
    n_checks++;
    if (e != int'(LAT) || {product_hi, product_lo} !== exp_p) begin
      n_fail++; $display("FAIL ignore_start_result: edges=%0d prod=%h required %0d %h", e, {product_hi, product_lo}, LAT, exp_p);
    end
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL ignore_start_pulses: %0d extra done pulses required 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    issue(64'h1111, 64'h2222);
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product_lo !== '0 || product_hi !== '0) begin
      n_fail++; $display("FAIL midreset_clear: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, product_hi, product_lo);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL midreset_quiet: %0d active cycles after abort required 0", pulses);
    end
  endtask

  task automatic test_random();
    int e, bb, nz, cy, cb;
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp_p;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i == 0) a[W-1] = 1'b1;
      exp_p = ref_mul(a, b);
      issue(a, b);
      multiplicand = ~a; multiplier = ~b;
      wait_done(0, e, bb, nz, cy, cb);
      n_checks++;
      if (e != int'(LAT) || {product_hi, product_lo} !== exp_p) begin
        n_fail++; $display("FAIL random_%0d: a=%h b=%h edges=%0d prod=%h required %h", i, a, b, e, {product_hi, product_lo}, exp_p);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e, bb, nz, cy, cb, lo_bad;
    @(negedge clk);
    multiplicand = 64'd2; multiplier = 64'd3; start = 1'b1;
    @(negedge clk);
    multiplicand = 64'h8000_0000_0000_0000; multiplier = 64'd2;
    wait_done(0, e, bb, nz, cy, cb);
    n_checks++;
    if (e != int'(LAT) || product_lo !== 64'd6 || product_hi !== 64'd0) begin
      n_fail++; $display("FAIL b2b_first: edges=%0d hi=%h lo=%h required %0d 0 6", e, product_hi, product_lo, LAT);
    end
    e = 0; lo_bad = 0;
    do begin
      @(negedge clk);
      e++;
      if (done !== 1'b1 && product_lo !== 64'd6) lo_bad++;
    end while (done !== 1'b1 && e < int'(BOUND));
    start = 1'b0;
    n_checks++;
    if (e != int'(LAT) + 1) begin
      n_fail++; $display("FAIL b2b_period: %0d cycles between done pulses required %0d", e, LAT + 1);
    end
    n_checks++;
    if (lo_bad != 0) begin
      n_fail++; $display("FAIL b2b_hold: product_lo changed on %0d cycles required 0", lo_bad);
    end
    n_checks++;
    if (product_hi !== 64'd1 || product_lo !== 64'd0) begin
      n_fail++; $display("FAIL b2b_second: hi=%h lo=%h required 1 0", product_hi, product_lo);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_stop: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_zero();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_back_to_back();
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
